// File: rtl/hv_pwm_intb_pkg.sv
// Shared constants and types for the HV-side pwm_intb_n burst encoder.
// The edge counts must match the LV-side decoder.
package hv_pwm_intb_pkg;

  localparam int INTB_ASSERT_EDGES   = 1;
  localparam int INTB_DEASSERT_EDGES = 3;

  localparam int DEF_TOGGLE_CYC  = 4;
  localparam int DEF_GAP_CYC     = 8;
  localparam int DEF_REFRESH_CYC = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDGE = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  // Level 0 (asserted) is one edge, level 1 (released) is three.
  function automatic logic [1:0] edges_for_level(input logic level);
    return level ? 2'(INTB_DEASSERT_EDGES) : 2'(INTB_ASSERT_EDGES);
  endfunction

endpackage

// File: rtl/hv_pwm_intb_encode_sched_timer.sv
// Loadable down-counter with zero flag; times both edge holds and the
// post-burst gap. Counts down to zero and then rests there.
module pwm_intb_burst_timer
  import hv_pwm_intb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load wins over decrement; the counter stalls at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == '0);

endmodule

// File: rtl/hv_pwm_intb_encode_sched.sv
// HV-side scheduler: encodes the interrupt level as 1-edge / 3-edge bursts
// on pwm_intb_n, with a gap after each burst and periodic refresh.
module hv_pwm_intb_encode_sched
  import hv_pwm_intb_pkg::*;
#(
  parameter int TOGGLE_CYC  = DEF_TOGGLE_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int REFRESH_CYC = DEF_REFRESH_CYC,
  parameter int TMR_W       = $clog2(((TOGGLE_CYC > GAP_CYC) ? TOGGLE_CYC : GAP_CYC) + 1),
  parameter int RFS_W       = (REFRESH_CYC > 0) ? $clog2(REFRESH_CYC + 1) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_intb_n,
  output logic o_pwm_intb_n,
  output logic o_busy,
  output logic o_sent_level,
  output logic o_burst_done,
  output logic o_refresh_pulse
);

  localparam logic [TMR_W-1:0] TOG_RELOAD = TMR_W'(TOGGLE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_RELOAD = TMR_W'(GAP_CYC - 1);
  localparam logic [RFS_W-1:0] RFS_LAST   = RFS_W'((REFRESH_CYC > 0) ? (REFRESH_CYC - 1) : 0);

  sched_state_t     state_r;
  sched_state_t     state_nxt;
  logic             chg_req;
  logic             rfs_exp;
  logic             start_burst;
  logic             start_level;
  logic             refresh_pulse;
  logic             timer_load;
  logic [TMR_W-1:0] timer_val;
  logic [TMR_W-1:0] timer_count;
  logic             timer_zero;
  logic [1:0]       remaining_r;
  logic             target_r;
  logic             line_r;
  logic             sent_level_r;
  logic             busy_r;
  logic             burst_done_r;
  logic [RFS_W-1:0] rfs_cnt_r;

  pwm_intb_burst_timer #(.W(TMR_W)) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (timer_load),
    .load_val (timer_val),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Burst-start decode in IDLE; a change request masks a coincident refresh.
  always_comb begin
    chg_req = 1'b0;
    rfs_exp = 1'b0;
    if (state_r == ST_IDLE && i_en) begin
      chg_req = (i_intb_n != sent_level_r);
      rfs_exp = (REFRESH_CYC != 0) && (rfs_cnt_r == RFS_LAST);
    end else begin
      chg_req = 1'b0;
      rfs_exp = 1'b0;
    end
    start_burst   = chg_req | rfs_exp;
    start_level   = chg_req ? i_intb_n : sent_level_r;
    refresh_pulse = rfs_exp & ~chg_req;
  end

  // Next-state and timer reload selection.
  always_comb begin
    state_nxt  = state_r;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_r)
      ST_IDLE: begin
        if (start_burst) begin
          state_nxt  = ST_EDGE;
          timer_load = 1'b1;
          timer_val  = TOG_RELOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EDGE: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          if (remaining_r != 2'd0) begin
            timer_val = TOG_RELOAD;
          end else begin
            state_nxt = ST_GAP;
            timer_val = GAP_RELOAD;
          end
        end else begin
          state_nxt = ST_EDGE;
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_GAP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Line, edge bookkeeping, sent level and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      line_r       <= 1'b1;
      busy_r       <= 1'b0;
      sent_level_r <= 1'b1;
      target_r     <= 1'b1;
      remaining_r  <= 2'd0;
      burst_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_burst) begin
            line_r      <= ~line_r;
            busy_r      <= 1'b1;
            target_r    <= start_level;
            remaining_r <= edges_for_level(start_level) - 2'd1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_EDGE: begin
          if (timer_zero && remaining_r != 2'd0) begin
            line_r      <= ~line_r;
            remaining_r <= remaining_r - 2'd1;
          end else begin
            remaining_r <= remaining_r;
          end
        end
        ST_GAP: begin
          if (timer_zero) begin
            sent_level_r <= target_r;
            busy_r       <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
      // Look one cycle ahead so the pulse lands on the final gap cycle.
      burst_done_r <= (state_r == ST_GAP) && (timer_count == TMR_W'(1));
    end
  end

  // Refresh idle counter: runs only while idle and enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rfs_cnt_r <= '0;
    end else if (!i_en || start_burst || REFRESH_CYC == 0) begin
      rfs_cnt_r <= '0;
    end else if (state_r == ST_IDLE) begin
      rfs_cnt_r <= rfs_cnt_r + RFS_W'(1);
    end else begin
      rfs_cnt_r <= rfs_cnt_r;
    end
  end

  assign o_pwm_intb_n    = line_r;
  assign o_busy          = busy_r;
  assign o_sent_level    = sent_level_r;
  assign o_burst_done    = burst_done_r;
  assign o_refresh_pulse = refresh_pulse;

endmodule

// File: tb/tb_hv_pwm_intb_encode_sched.sv
// Scoreboard bench: stimulus pushes expected timed events, a negedge monitor
// pops and compares every observed line/flag event.
module tb_hv_pwm_intb_encode_sched;

  localparam int EV_REFRESH = 0;
  localparam int EV_BUSY    = 1;
  localparam int EV_EDGE    = 2;
  localparam int EV_DONE    = 3;
  localparam int EV_LEVEL   = 4;

  typedef struct {
    int   kind;
    int   cyc;
    logic val;
  } ev_t;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_en = 1'b1;
  logic i_intb_n = 1'b1;
  logic o_pwm_intb_n, o_busy, o_sent_level, o_burst_done, o_refresh_pulse;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  ev_t exp_q[$];
  logic line_model = 1'b1;
  logic sent_model = 1'b1;

  hv_pwm_intb_encode_sched #(
    .TOGGLE_CYC (4),
    .GAP_CYC    (8),
    .REFRESH_CYC(64)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .i_intb_n       (i_intb_n),
    .o_pwm_intb_n   (o_pwm_intb_n),
    .o_busy         (o_busy),
    .o_sent_level   (o_sent_level),
    .o_burst_done   (o_burst_done),
    .o_refresh_pulse(o_refresh_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d required=finish before limit", cyc);
    $fatal(1, "watchdog");
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input int c, input logic v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Expected event timeline of one burst started on cycle s with n edges.
  task automatic expect_burst(input int s, input int n, input bit rfs, input logic lvl);
    if (rfs) push(EV_REFRESH, s, 1'b1);
    push(EV_BUSY, s + 1, 1'b1);
    for (int k = 0; k < n; k++) begin
      line_model = ~line_model;
      push(EV_EDGE, s + 1 + 4 * k, line_model);
    end
    push(EV_DONE, s + 4 * n + 8, 1'b1);
    push(EV_BUSY, s + 4 * n + 9, 1'b0);
    if (lvl != sent_model) push(EV_LEVEL, s + 4 * n + 9, lvl);
    sent_model = lvl;
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0b required=%0b", name, cyc, act, req);
    end
  endtask

  task automatic observe(input int kind, input logic v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got kind=%0d cycle=%0d val=%0b required=none", kind, cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== v) begin
        failures++;
        $display("FAIL event got kind=%0d cycle=%0d val=%0b required kind=%0d cycle=%0d val=%0b",
                 kind, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  logic primed = 1'b0;
  logic prev_line, prev_busy, prev_sent;

  // Monitor: turn output activity into ordered events and score them.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (primed) begin
        if (o_refresh_pulse === 1'b1) observe(EV_REFRESH, 1'b1);
        if (o_busy !== prev_busy) observe(EV_BUSY, o_busy);
        if (o_pwm_intb_n !== prev_line) observe(EV_EDGE, o_pwm_intb_n);
        if (o_burst_done === 1'b1) observe(EV_DONE, 1'b1);
        if (o_sent_level !== prev_sent) observe(EV_LEVEL, o_sent_level);
      end
      primed    = 1'b1;
      prev_line = o_pwm_intb_n;
      prev_busy = o_busy;
      prev_sent = o_sent_level;
    end
  end

  initial begin
    // Reset held during cycle 0 only.
    goto(1);
    i_rst = 1'b0;
    check_bit("rst_line", o_pwm_intb_n, 1'b1);
    check_bit("rst_busy", o_busy, 1'b0);
    check_bit("rst_sent", o_sent_level, 1'b1);
    check_bit("rst_done", o_burst_done, 1'b0);
    check_bit("rst_refresh", o_refresh_pulse, 1'b0);

    // Assert: one edge at 11, done at 22, level 0 at 23.
    expect_burst(10, 1, 1'b0, 1'b0);
    goto(10); i_intb_n = 1'b0;

    // Release: edges 41/45/49, done 60, level 1 at 61.
    expect_burst(40, 3, 1'b0, 1'b1);
    goto(40); i_intb_n = 1'b1;

    // Reset while idle, then two refreshes 84 cycles apart.
    goto(100); i_rst = 1'b1;
    goto(101); i_rst = 1'b0;
    check_bit("rst2_sent", o_sent_level, 1'b1);
    check_bit("rst2_busy", o_busy, 1'b0);
    expect_burst(164, 3, 1'b1, 1'b1);
    expect_burst(248, 3, 1'b1, 1'b1);

    // Change request coincides with refresh expiry at 332: no refresh pulse.
    expect_burst(332, 1, 1'b0, 1'b0);
    // Counter restarted from that burst: next refresh at 408.
    expect_burst(408, 1, 1'b1, 1'b0);
    goto(332); i_intb_n = 1'b0;

    // Release at 430 with a glitch inside the burst; no follow-up burst.
    expect_burst(430, 3, 1'b0, 1'b1);
    goto(430); i_intb_n = 1'b1;
    goto(433); i_intb_n = 1'b0;
    goto(436); i_intb_n = 1'b1;

    // Refresh at 514, reset sampled on the second edge at 519.
    push(EV_REFRESH, 514, 1'b1);
    push(EV_BUSY, 515, 1'b1);
    push(EV_EDGE, 515, 1'b1);
    push(EV_EDGE, 519, 1'b0);
    push(EV_BUSY, 520, 1'b0);
    push(EV_EDGE, 520, 1'b1);
    goto(519); i_rst = 1'b1; i_en = 1'b0; i_intb_n = 1'b0;
    goto(520); i_rst = 1'b0;
    check_bit("midrst_line", o_pwm_intb_n, 1'b1);
    check_bit("midrst_busy", o_busy, 1'b0);
    check_bit("midrst_sent", o_sent_level, 1'b1);
    check_bit("midrst_done", o_burst_done, 1'b0);

    // Disabled with a pending change: silence for 200 cycles.
    goto(722);
    check_bit("disabled_sent", o_sent_level, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got pending=%0d required=0 next_cycle=%0d", exp_q.size(), exp_q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
